overlap_window_split: RTL
=========================

Name: overlap_window_split

Overview:
- Window splitter for the transposed-convolution datapath. It is the producer-side counterpart of the overlap-add column accumulator, which sums overlapping output columns.
- Takes a stream of input columns for one row, each column SIZE_OF_INPUT pixels wide.
- Re-emits the row as SIZE_OF_FEATURE overlapping windows of SIZE_OF_WEIGHT columns, advancing STRIDE columns between windows and replicating the overlap region.
- Uses valid/ready handshakes on both sides.

Parameters:
- PIX_WIDTH, 8, bits per pixel
- SIZE_OF_INPUT, 5, pixels per column
- SIZE_OF_FEATURE, 2, windows per row
- SIZE_OF_WEIGHT, 5, columns per window (W)
- STRIDE, 2, column advance between windows; legal range 1..SIZE_OF_WEIGHT

Ports:
- clk_i, in, 1, clock; single clock domain.
- rst_i, in, 1, reset; synchronous, active-high.
- valid_i, in, 1, input column valid.
- buffer_i, in, SIZE_OF_INPUT*PIX_WIDTH, input column.
- ready_o, out, 1, block can accept a column.
- buffer_o, out, SIZE_OF_INPUT*PIX_WIDTH, output column.
- valid_o, out, 1, buffer_o valid.
- ready_i, in, 1, downstream accepts buffer_o.
- feat_idx_o, out, clog2(SIZE_OF_FEATURE)+1, current window index.
- tap_idx_o, out, clog2(SIZE_OF_WEIGHT)+1, column index within the window.
- last_o, out, 1, final column of the row (last tap of last window).

Behaviour:
- Row length in: R = (SIZE_OF_FEATURE-1)*STRIDE + SIZE_OF_WEIGHT columns. Row length out: SIZE_OF_FEATURE*SIZE_OF_WEIGHT columns.
- Storage: column buffer of depth W, addressed by head pointer (oldest column) and count cnt (0..W). Pointers wrap modulo W.
- States:
  - FILL: ready_o = (cnt < W). An input handshake (valid_i & ready_o) writes at (head+cnt) mod W and increments cnt. When cnt reaches W (including the handshake that makes it W), next state is EMIT.
  - EMIT: ready_o = 0 and valid_o = 1. buffer_o = buf[(head+tap) mod W], driven from registers through a mux with no input-to-output combinational path. On each output handshake (valid_o & ready_i), tap increments.
- End of window, on the handshake with tap == W-1:
  - If feat < SIZE_OF_FEATURE-1: head += STRIDE (mod W), cnt -= STRIDE, feat++, tap = 0, next state FILL.
  - Else: last_o = 1 during this column; cnt = 0, head = 0, feat = 0, tap = 0, next state FILL (next row).
- STRIDE == W: no column reuse; each window needs W fresh columns.
- SIZE_OF_FEATURE == 1: single window, and last_o is asserted on tap W-1.
- Stall: while ready_i = 0 in EMIT, buffer_o, valid_o, feat_idx_o, tap_idx_o and last_o hold stable.
- valid_i while ready_o = 0 is ignored; no write and no state change.
- Latency: the first output column is valid the cycle after the W-th input handshake.
- Throughput (no stalls, defaults): 17 cycles per row, made of fill 5, emit 5, fill 2 and emit 5.
- Input and output never handshake in the same cycle. This is a deliberate simplification.
- Reset (rst_i = 1 at a clock edge), from any state including mid-window:
  - state = FILL; cnt, head, tap and feat = 0.
  - valid_o = 0, last_o = 0, buffer_o = 0, feat_idx_o = 0, tap_idx_o = 0, ready_o = 1 on the next cycle.
  - Buffer contents need not be cleared.
- Index outputs are 0 when valid_o = 0.
- Pixels pass through unmodified; no arithmetic on data.
- Illegal STRIDE (0 or > W) is a parameter error, flagged by an elaboration-time check.

Decomposition:
- Shared package/include holds:
  - COL_W = SIZE_OF_INPUT*PIX_WIDTH
  - ROW_IN_COLS (R) and ROW_OUT_COLS
  - index widths
  - state encoding FILL/EMIT
- Natural sub-module: overlap_col_ring. It is a W-deep column ring buffer with push, pop-N (N = STRIDE), clear, and a random read port at offset tap.
- The top level contains the FSM and the tap/feature counters.

Test Plan:
- Basic row, defaults, ready_i = 1: input columns carry all pixels = c for c = 0..6 → output column order 0,1,2,3,4,2,3,4,5,6. feat_idx_o is 0×5 then 1×5, tap_idx_o is 0..4 twice, last_o only on the 10th column; 17 cycles total.
- Back-to-back rows: 14 input columns (values 0..13) → second-row output 7,8,9,10,11,9,10,11,12,13, with no residue from row 1.
- Backpressure: ready_i toggles 1,0,0,1 during EMIT → each column is held stable while stalled, with no duplicates or drops; ready_o stays 0 throughout EMIT.
- Ignored input: valid_i = 1 with value 0xFF during EMIT → column is not stored; next window output is unchanged.
- STRIDE = 5 (== W), SIZE_OF_FEATURE = 2: 10 inputs 0..9 → outputs 0..9 in order; FILL accepts 5 columns between windows.
- Reset mid-window: rst_i = 1 at tap 2 of window 0 → next cycle valid_o = 0, ready_o = 1. A fresh row 0..6 then yields exactly the basic-row output.

Source files
------------

// File: rtl/overlap_window_split_pkg.sv
// Shared definitions for the overlap window splitter.
//   - default parameter set and the widths derived from it
//   - helper functions so any parameterisation derives the same widths
//   - FSM state encoding
package overlap_window_split_pkg;

    localparam int DEF_PIX_WIDTH       = 8;
    localparam int DEF_SIZE_OF_INPUT   = 5;
    localparam int DEF_SIZE_OF_FEATURE = 2;
    localparam int DEF_SIZE_OF_WEIGHT  = 5;
    localparam int DEF_STRIDE          = 2;

    // Columns consumed per row: windows share (W - STRIDE) columns.
    function automatic int row_in_cols(input int f, input int s, input int w);
        return (f - 1) * s + w;
    endfunction

    // Columns produced per row: every window is emitted in full.
    function automatic int row_out_cols(input int f, input int w);
        return f * w;
    endfunction

    // Index/count width able to hold 0..n.
    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Pointer width addressing 0..n-1 (at least one bit).
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W        = DEF_SIZE_OF_INPUT * DEF_PIX_WIDTH;
    localparam int ROW_IN_COLS  = row_in_cols(DEF_SIZE_OF_FEATURE, DEF_STRIDE, DEF_SIZE_OF_WEIGHT);
    localparam int ROW_OUT_COLS = row_out_cols(DEF_SIZE_OF_FEATURE, DEF_SIZE_OF_WEIGHT);
    localparam int FEAT_W       = idx_w(DEF_SIZE_OF_FEATURE);
    localparam int TAP_W        = idx_w(DEF_SIZE_OF_WEIGHT);

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/overlap_window_split_if.sv
// Stream boundary of the window splitter.
//   valid_i/buffer_i/ready_o       : column input handshake
//   valid_o/buffer_o/ready_i       : column output handshake
//   feat_idx_o/tap_idx_o/last_o    : sideband describing the output column
// slave  : the splitter itself
// master : the environment (upstream producer + downstream consumer)
interface overlap_window_split_if #(
    parameter int COL_W  = overlap_window_split_pkg::COL_W,
    parameter int FEAT_W = overlap_window_split_pkg::FEAT_W,
    parameter int TAP_W  = overlap_window_split_pkg::TAP_W
) ();
    logic              valid_i;
    logic [COL_W-1:0]  buffer_i;
    logic              ready_o;
    logic [COL_W-1:0]  buffer_o;
    logic              valid_o;
    logic              ready_i;
    logic [FEAT_W-1:0] feat_idx_o;
    logic [TAP_W-1:0]  tap_idx_o;
    logic              last_o;

    modport slave (
        input  valid_i, buffer_i, ready_i,
        output ready_o, buffer_o, valid_o, feat_idx_o, tap_idx_o, last_o
    );

    modport master (
        output valid_i, buffer_i, ready_i,
        input  ready_o, buffer_o, valid_o, feat_idx_o, tap_idx_o, last_o
    );
endinterface

// File: rtl/overlap_window_split_col.sv
// overlap_col_ring: DEPTH-deep column ring buffer.
//   clk_i, rst_i : clock, synchronous active-high reset (pointers only)
//   push_i       : write data_i at (head + cnt) mod DEPTH, cnt++
//   pop_i        : retire STRIDE oldest columns (head += STRIDE, cnt -= STRIDE)
//   clear_i      : drop everything (head = 0, cnt = 0)
//   tap_i        : read offset from head; rd_data_o = mem[(head + tap) mod DEPTH]
//   cnt_o        : number of columns held (0..DEPTH)
// Priority is clear > pop > push; the owner never pushes and pops together.
module overlap_col_ring
    import overlap_window_split_pkg::*;
#(
    parameter int COL_W  = overlap_window_split_pkg::COL_W,
    parameter int DEPTH  = DEF_SIZE_OF_WEIGHT,
    parameter int STRIDE = DEF_STRIDE,
    parameter int PTR_W  = ptr_w(DEPTH),
    parameter int CNT_W  = idx_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [COL_W-1:0] data_i,
    input  logic [PTR_W-1:0] tap_i,
    output logic [COL_W-1:0] rd_data_o,
    output logic [CNT_W-1:0] cnt_o
);
    logic [DEPTH-1:0][COL_W-1:0] mem_q;
    logic [PTR_W-1:0]            head_q, head_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;

    // Both operands are < DEPTH (cnt == DEPTH never writes), so one
    // conditional subtract is a complete modulo.
    function automatic logic [PTR_W-1:0] wrap_add(input int a, input int b);
        int s = a + b;
        return PTR_W'((s >= DEPTH) ? s - DEPTH : s);
    endfunction

    assign wr_ptr    = wrap_add(int'(head_q), int'(cnt_q));
    assign rd_ptr    = wrap_add(int'(head_q), int'(tap_i));
    assign rd_data_o = mem_q[rd_ptr];
    assign cnt_o     = cnt_q;

    always_comb begin
        head_d = head_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            head_d = '0;
            cnt_d  = '0;
        end else if (pop_i) begin
            head_d = wrap_add(int'(head_q), STRIDE);
            cnt_d  = cnt_q - CNT_W'(STRIDE);
        end else if (push_i) begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is never reset: cnt gates what is considered valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/overlap_window_split.sv
// overlap_window_split: re-emits one row of input columns as SIZE_OF_FEATURE
// overlapping windows of SIZE_OF_WEIGHT columns, advancing STRIDE columns
// between windows so the overlap region is replayed from the ring buffer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus.valid_i/buffer_i/ready_o : column input (accepted only in FILL)
//   bus.valid_o/buffer_o/ready_i : column output (driven only in EMIT)
//   bus.feat_idx_o/tap_idx_o     : window / column-in-window of buffer_o
//   bus.last_o                   : last tap of last window (end of row)
// Input and output never handshake in the same cycle: FILL only accepts,
// EMIT only emits.
module overlap_window_split
    import overlap_window_split_pkg::*;
#(
    parameter int PIX_WIDTH       = DEF_PIX_WIDTH,
    parameter int SIZE_OF_INPUT   = DEF_SIZE_OF_INPUT,
    parameter int SIZE_OF_FEATURE = DEF_SIZE_OF_FEATURE,
    parameter int SIZE_OF_WEIGHT  = DEF_SIZE_OF_WEIGHT,
    parameter int STRIDE          = DEF_STRIDE
) (
    input logic                   clk_i,
    input logic                   rst_i,
    overlap_window_split_if.slave bus
);
    localparam int COL_BITS  = SIZE_OF_INPUT * PIX_WIDTH;
    localparam int FEAT_BITS = idx_w(SIZE_OF_FEATURE);
    localparam int TAP_BITS  = idx_w(SIZE_OF_WEIGHT);
    localparam int PTR_BITS  = ptr_w(SIZE_OF_WEIGHT);

    localparam logic [TAP_BITS-1:0]  TAP_LAST  = TAP_BITS'(SIZE_OF_WEIGHT - 1);
    localparam logic [TAP_BITS-1:0]  CNT_FULL  = TAP_BITS'(SIZE_OF_WEIGHT);
    localparam logic [TAP_BITS-1:0]  CNT_PRE   = TAP_BITS'(SIZE_OF_WEIGHT - 1);
    localparam logic [FEAT_BITS-1:0] FEAT_LAST = FEAT_BITS'(SIZE_OF_FEATURE - 1);

    if (STRIDE < 1 || STRIDE > SIZE_OF_WEIGHT) begin : g_bad_stride
        $error("overlap_window_split: STRIDE must be in 1..SIZE_OF_WEIGHT");
    end

    state_e               state_q;
    logic [TAP_BITS-1:0]  tap_q;
    logic [FEAT_BITS-1:0] feat_q;
    logic [TAP_BITS-1:0]  cnt;
    logic [COL_BITS-1:0]  rd_data;
    logic                 in_hs, out_hs, win_end, row_end;
    logic                 emit;

    assign emit    = (state_q == EMIT);
    assign in_hs   = bus.valid_i & bus.ready_o;
    assign out_hs  = bus.valid_o & bus.ready_i;
    assign win_end = out_hs & (tap_q == TAP_LAST);
    assign row_end = win_end & (feat_q == FEAT_LAST);

    overlap_col_ring #(
        .COL_W  (COL_BITS),
        .DEPTH  (SIZE_OF_WEIGHT),
        .STRIDE (STRIDE)
    ) u_ring (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (in_hs),
        .pop_i     (win_end & ~row_end),
        .clear_i   (row_end),
        .data_i    (bus.buffer_i),
        .tap_i     (PTR_BITS'(tap_q)),
        .rd_data_o (rd_data),
        .cnt_o     (cnt)
    );

    // All outputs decode registered state only, so nothing on the input
    // side reaches the output side combinationally; they hold under stall
    // because the registers only move on a handshake.
    assign bus.ready_o    = ~emit & (cnt < CNT_FULL);
    assign bus.valid_o    = emit;
    assign bus.buffer_o   = emit ? rd_data : '0;
    assign bus.feat_idx_o = emit ? feat_q  : '0;
    assign bus.tap_idx_o  = emit ? tap_q   : '0;
    assign bus.last_o     = emit & (tap_q == TAP_LAST) & (feat_q == FEAT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            tap_q   <= '0;
            feat_q  <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    // Window complete either already (cnt == W) or with the
                    // handshake landing this cycle.
                    if ((cnt == CNT_FULL) || (in_hs && (cnt == CNT_PRE)))
                        state_q <= EMIT;
                end
                EMIT: begin
                    if (out_hs) begin
                        if (tap_q == TAP_LAST) begin
                            tap_q   <= '0;
                            state_q <= FILL;
                            feat_q  <= row_end ? '0 : feat_q + FEAT_BITS'(1);
                        end else begin
                            tap_q   <= tap_q + TAP_BITS'(1);
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule
